// File: rtl/grid_readout.sv
// Streams a snapshot of the grid state out as word_size words, LSW first, over valid/ready.
// Define GRID_READOUT_CHECKSUM_EN to append an XOR checksum word to every frame.
module grid_readout #(
  parameter int unsigned data_size = 64,
  parameter int unsigned word_size = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [data_size-1:0] GRID_STATE,
  input  logic                 START,
  input  logic                 OUT_READY,
  output logic [word_size-1:0] OUT_WORD,
  output logic                 OUT_VALID,
  output logic                 OUT_LAST,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned NumWords = data_size / word_size;
  localparam int unsigned CntW     = $clog2(NumWords);
  localparam logic [CntW-1:0] LastIdx = CntW'(NumWords - 1);

`ifdef GRID_READOUT_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCheck} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

  state_e                 state_q;
  logic [data_size-1:0]   snap_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        cnt_nxt;
  logic [word_size-1:0]   word_nxt;
  logic [word_size-1:0]   out_word_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   done_q;

  // Word that follows the one currently presented.
  always_comb begin
    cnt_nxt  = cnt_q + 1'b1;
    word_nxt = '0;
    for (int i = 0; i < NumWords; i++) begin
      if (cnt_nxt == CntW'(i)) word_nxt = snap_q[i*word_size +: word_size];
    end
  end

`ifdef GRID_READOUT_CHECKSUM_EN
  logic [word_size-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < NumWords; i++) csum = csum ^ snap_q[i*word_size +: word_size];
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      cnt_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (START) begin
            snap_q      <= GRID_STATE;
            cnt_q       <= '0;
            state_q     <= StSend;
            out_word_q  <= GRID_STATE[word_size-1:0];
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        StSend: begin
          if (OUT_READY) begin
            if (cnt_q == LastIdx) begin
              cnt_q <= '0;
`ifdef GRID_READOUT_CHECKSUM_EN
              state_q    <= StCheck;
              out_word_q <= csum;
              out_last_q <= 1'b1;
`else
              state_q     <= StIdle;
              out_word_q  <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
`endif
            end else begin
              cnt_q      <= cnt_nxt;
              out_word_q <= word_nxt;
`ifdef GRID_READOUT_CHECKSUM_EN
              out_last_q <= 1'b0;
`else
              out_last_q <= (cnt_nxt == LastIdx);
`endif
            end
          end
        end
`ifdef GRID_READOUT_CHECKSUM_EN
        StCheck: begin
          if (OUT_READY) begin
            state_q     <= StIdle;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign OUT_WORD  = out_word_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_LAST  = out_last_q;
  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;

endmodule

// File: tb/tb_grid_readout.sv
// Directed, table-driven bench for grid_readout with data_size=16, word_size=4.
// Follows GRID_READOUT_CHECKSUM_EN to expect the extra checksum word when it is defined.
module tb_grid_readout;

  localparam int unsigned DS = 16;
  localparam int unsigned WS = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [DS-1:0] GRID_STATE;
  logic          START;
  logic          OUT_READY;
  logic [WS-1:0] OUT_WORD;
  logic          OUT_VALID;
  logic          OUT_LAST;
  logic          BUSY;
  logic          DONE;

  grid_readout #(
    .data_size(DS),
    .word_size(WS)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .GRID_STATE(GRID_STATE),
    .START     (START),
    .OUT_READY (OUT_READY),
    .OUT_WORD  (OUT_WORD),
    .OUT_VALID (OUT_VALID),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          start;
    logic          ready;
    logic [DS-1:0] grid;
    logic [WS-1:0] word;
    logic          valid;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic add(input logic s, input logic r, input logic [DS-1:0] g, input logic [WS-1:0] w,
                     input logic v, input logic l, input logic b, input logic d);
    vecs.push_back('{s, r, g, w, v, l, b, d});
  endtask

  task automatic expect_out(input string name, input logic [WS-1:0] w, input logic v,
                            input logic l, input logic b, input logic d);
    nvec++;
    if (OUT_WORD !== w || OUT_VALID !== v || OUT_LAST !== l || BUSY !== b || DONE !== d) begin
      nerr++;
      $display("FAIL %s: got word=%h valid=%b last=%b busy=%b done=%b, want word=%h valid=%b last=%b busy=%b done=%b",
               name, OUT_WORD, OUT_VALID, OUT_LAST, BUSY, DONE, w, v, l, b, d);
    end
  endtask

  initial begin
    // Basic frame 16'h1234 with ready held high.
    add(0, 1, 16'h1234, 4'h0, 0, 0, 0, 0);
    add(1, 1, 16'h1234, 4'h4, 1, 0, 1, 0);
    add(0, 1, 16'h1234, 4'h3, 1, 0, 1, 0);
    add(0, 1, 16'h1234, 4'h2, 1, 0, 1, 0);
`ifdef GRID_READOUT_CHECKSUM_EN
    add(0, 1, 16'h1234, 4'h1, 1, 0, 1, 0);
    add(0, 1, 16'h1234, 4'h4, 1, 1, 1, 0);
`else
    add(0, 1, 16'h1234, 4'h1, 1, 1, 1, 0);
`endif
    add(0, 1, 16'h1234, 4'h0, 0, 0, 0, 1);
    add(0, 1, 16'h1234, 4'h0, 0, 0, 0, 0);
    // Backpressure, grid change and START pulses during the frame.
    add(1, 0, 16'h1234, 4'h4, 1, 0, 1, 0);
    add(1, 0, 16'hFFFF, 4'h4, 1, 0, 1, 0);
    add(0, 1, 16'hFFFF, 4'h3, 1, 0, 1, 0);
    add(0, 0, 16'hFFFF, 4'h3, 1, 0, 1, 0);
    add(1, 0, 16'hFFFF, 4'h3, 1, 0, 1, 0);
    add(0, 1, 16'hFFFF, 4'h2, 1, 0, 1, 0);
`ifdef GRID_READOUT_CHECKSUM_EN
    add(0, 1, 16'hFFFF, 4'h1, 1, 0, 1, 0);
    add(0, 0, 16'hFFFF, 4'h1, 1, 0, 1, 0);
    add(0, 1, 16'hFFFF, 4'h4, 1, 1, 1, 0);
    add(0, 0, 16'hFFFF, 4'h4, 1, 1, 1, 0);
`else
    add(0, 1, 16'hFFFF, 4'h1, 1, 1, 1, 0);
    add(0, 0, 16'hFFFF, 4'h1, 1, 1, 1, 0);
`endif
    add(0, 1, 16'hFFFF, 4'h0, 0, 0, 0, 1);
    add(0, 1, 16'hFFFF, 4'h0, 0, 0, 0, 0);
    // START held high across DONE: second frame captures the new grid.
    add(1, 1, 16'h5678, 4'h8, 1, 0, 1, 0);
    add(1, 1, 16'hABCD, 4'h7, 1, 0, 1, 0);
    add(1, 1, 16'hABCD, 4'h6, 1, 0, 1, 0);
`ifdef GRID_READOUT_CHECKSUM_EN
    add(1, 1, 16'hABCD, 4'h5, 1, 0, 1, 0);
    add(1, 1, 16'hABCD, 4'hC, 1, 1, 1, 0);
`else
    add(1, 1, 16'hABCD, 4'h5, 1, 1, 1, 0);
`endif
    add(1, 1, 16'hABCD, 4'h0, 0, 0, 0, 1);
    add(1, 1, 16'hABCD, 4'hD, 1, 0, 1, 0);
    add(0, 1, 16'hABCD, 4'hC, 1, 0, 1, 0);
    add(0, 1, 16'hABCD, 4'hB, 1, 0, 1, 0);
`ifdef GRID_READOUT_CHECKSUM_EN
    add(0, 1, 16'hABCD, 4'hA, 1, 0, 1, 0);
    add(0, 1, 16'hABCD, 4'h0, 1, 1, 1, 0);
`else
    add(0, 1, 16'hABCD, 4'hA, 1, 1, 1, 0);
`endif
    add(0, 1, 16'hABCD, 4'h0, 0, 0, 0, 1);
    add(0, 1, 16'hABCD, 4'h0, 0, 0, 0, 0);

    RESET      = 1'b0;
    START      = 1'b0;
    OUT_READY  = 1'b0;
    GRID_STATE = '0;
    #2;
    expect_out("reset_state", 4'h0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      START      = vecs[i].start;
      OUT_READY  = vecs[i].ready;
      GRID_STATE = vecs[i].grid;
      @(posedge CLK);
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].word, vecs[i].valid, vecs[i].last,
                 vecs[i].busy, vecs[i].done);
    end

    // Asynchronous reset in the middle of a frame.
    START      = 1'b1;
    OUT_READY  = 1'b1;
    GRID_STATE = 16'h1234;
    @(posedge CLK);
    #1;
    expect_out("abort_first", 4'h4, 1, 0, 1, 0);
    START = 1'b0;
    @(posedge CLK);
    #1;
    expect_out("abort_second", 4'h3, 1, 0, 1, 0);
    #2;
    RESET = 1'b0;
    #1;
    expect_out("async_reset", 4'h0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      expect_out($sformatf("post_reset_idle%0d", i), 4'h0, 0, 0, 0, 0);
    end
    START      = 1'b1;
    GRID_STATE = 16'h9ABC;
    @(posedge CLK);
    #1;
    expect_out("restart_word0", 4'hC, 1, 0, 1, 0);
    START     = 1'b0;
    OUT_READY = 1'b0;
    @(posedge CLK);
    #1;
    expect_out("restart_stall", 4'hC, 1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
